// File: rtl/web_pkg.sv
// Shared definitions for the web fire sequencer: function/response codes, FSM states, costs.
// Pure declarations, no logic and no latency.
// No handshake of its own; consumers own all flow control.
package web_pkg;

    localparam logic [2:0] FUNC_NOP    = 3'b000;
    localparam logic [2:0] FUNC_LINE   = 3'b001;
    localparam logic [2:0] FUNC_BALL   = 3'b010;
    localparam logic [2:0] FUNC_TRACER = 3'b011;
    localparam logic [2:0] FUNC_TASER  = 3'b100;

    typedef enum logic [1:0] {
        RESP_OK        = 2'b00,
        RESP_INVALID   = 2'b01,
        RESP_NO_ENERGY = 2'b10,
        RESP_NO_TRACER = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_FIRE     = 3'd2,
        ST_RESP     = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_e;

    localparam logic [7:0] COST_E_LINE   = 8'd1;
    localparam logic [7:0] COST_E_BALL   = 8'd2;
    localparam logic [7:0] COST_E_TRACER = 8'd1;
    localparam logic [7:0] COST_E_TASER  = 8'd4;
    localparam logic [5:0] COST_T_TRACER = 6'd1;

    localparam logic [5:0] TRACER_MAX = 6'd63;

endpackage

// File: rtl/web_cost_lut.sv
// Decodes a web function into its energy cost, tracer cost and an invalid flag.
// Purely combinational, zero latency.
// No handshake; outputs follow funcSel directly.
module web_cost_lut
    import web_pkg::*;
(
    input  logic [2:0] funcSel,
    output logic [7:0] energyCost,
    output logic [5:0] tracerCost,
    output logic       invalid
);

    always_comb begin
        energyCost = '0;
        tracerCost = '0;
        invalid    = 1'b0;
        case (funcSel)
            FUNC_NOP:    ;
            FUNC_LINE:   energyCost = COST_E_LINE;
            FUNC_BALL:   energyCost = COST_E_BALL;
            FUNC_TRACER: begin
                energyCost = COST_E_TRACER;
                tracerCost = COST_T_TRACER;
            end
            FUNC_TASER:  energyCost = COST_E_TASER;
            default:     invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/web_fire_sequencer.sv
// Single-shot web fire controller: checks reserves, strobes one fire command, then cools down.
// Accept edge N -> fire/resp strobe in cycle N+2; next accept at N+3 (reject) or N+3+COOLDOWN_CYCLES.
// req_ready only in IDLE; optional reserve reload via WEB_RELOAD_EN.
module web_fire_sequencer
    import web_pkg::*;
#(
    parameter logic [7:0]  ENERGY_MAX      = 8'd255,
    parameter logic [5:0]  TRACER_INIT     = 6'd32,
    parameter int unsigned COOLDOWN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  func_sel,
    input  logic [3:0]  target_sel,
    input  logic [7:0]  x_coord,
    input  logic [7:0]  y_coord,
    input  logic [7:0]  z_coord,
    input  logic [7:0]  t_coord,
`ifdef WEB_RELOAD_EN
    input  logic        reload_req,
`endif
    output logic        fire_valid,
    output logic [2:0]  fire_func,
    output logic [3:0]  fire_target,
    output logic [31:0] fire_coord,
    output logic        resp_valid,
    output logic [1:0]  resp_code,
    output logic [5:0]  tracer_count,
    output logic [7:0]  energy_level,
    output logic        energy_empty
);

    localparam logic [3:0] CD_LOAD = 4'(COOLDOWN_CYCLES);

    state_e      state;
    state_e      stateNext;
    logic [2:0]  reqFunc;
    logic [3:0]  reqTarget;
    logic [31:0] reqCoord;
    logic [7:0]  energyCost;
    logic [5:0]  tracerCost;
    logic        costInvalid;
    resp_e       checkCode;
    resp_e       respCode;
    logic        checkFire;
    logic [3:0]  cdCnt;
    logic [7:0]  energyLevel;
    logic [5:0]  tracerCount;
    logic [2:0]  fireFunc;
    logic [3:0]  fireTarget;
    logic [31:0] fireCoord;
    logic        reloadHit;

    web_cost_lut u_cost_lut (
        .funcSel    (reqFunc),
        .energyCost (energyCost),
        .tracerCost (tracerCost),
        .invalid    (costInvalid)
    );

    // Rejection priority: invalid function, then energy, then tracer.
    always_comb begin
        checkCode = RESP_OK;
        if (costInvalid)
            checkCode = RESP_INVALID;
        else if (energyLevel < energyCost)
            checkCode = RESP_NO_ENERGY;
        else if (tracerCount < tracerCost)
            checkCode = RESP_NO_TRACER;
    end

    assign checkFire = (checkCode == RESP_OK) && (reqFunc != FUNC_NOP);

`ifdef WEB_RELOAD_EN
    assign reloadHit = (state == ST_IDLE) && !req_valid && reload_req;
`else
    assign reloadHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        req_ready  = 1'b0;
        fire_valid = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    stateNext = ST_CHECK;
            end
            ST_CHECK:  stateNext = checkFire ? ST_FIRE : ST_RESP;
            ST_FIRE: begin
                fire_valid = 1'b1;
                resp_valid = 1'b1;
                stateNext  = ST_COOLDOWN;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                stateNext  = ST_IDLE;
            end
            ST_COOLDOWN: begin
                if (cdCnt <= 4'd1)
                    stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqFunc     <= '0;
            reqTarget   <= '0;
            reqCoord    <= '0;
            respCode    <= RESP_OK;
            fireFunc    <= '0;
            fireTarget  <= '0;
            fireCoord   <= '0;
            cdCnt       <= '0;
            energyLevel <= ENERGY_MAX;
            tracerCount <= TRACER_INIT;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                reqFunc   <= func_sel;
                reqTarget <= target_sel;
                reqCoord  <= {t_coord, z_coord, y_coord, x_coord};
            end
            if (state == ST_CHECK) begin
                respCode <= checkCode;
                // Fire outputs only move on an accepted shot so they hold between fires.
                if (checkFire) begin
                    fireFunc   <= reqFunc;
                    fireTarget <= reqTarget;
                    fireCoord  <= reqCoord;
                end
            end
            if (state == ST_FIRE) begin
                energyLevel <= energyLevel - energyCost;
                tracerCount <= tracerCount - tracerCost;
                cdCnt       <= CD_LOAD;
            end
            if (state == ST_COOLDOWN && cdCnt != 4'd0)
                cdCnt <= cdCnt - 4'd1;
            if (reloadHit) begin
                energyLevel <= ENERGY_MAX;
                tracerCount <= TRACER_MAX;
            end
        end
    end

    assign resp_code    = respCode;
    assign fire_func    = fireFunc;
    assign fire_target  = fireTarget;
    assign fire_coord   = fireCoord;
    assign tracer_count = tracerCount;
    assign energy_level = energyLevel;
    assign energy_empty = (energyLevel == 8'd0);

endmodule

// File: doc/web_fire_sequencer.md
# web_fire_sequencer

Controller sitting in front of the WebShooter datapath: accepts one web-function request at a time, checks it against the tracer and energy reserves, and issues a single fire command with the latched target telemetry. It decrements reserves and then enforces a cooldown before the next shot. It owns the `tracerCount` and `energyEmpty` values the top level reports.

## Interface
- `ENERGY_MAX`, 255: energy reserve after reset/reload, 8-bit.
- `TRACER_INIT`, 32: tracer count after reset, 6-bit.
- `COOLDOWN_CYCLES`, 4: idle cycles forced after every fire, range 1..15.
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `func_sel` in 3: web function; 000 NOP, 001 line, 010 ball, 011 tracer, 100 taser, 101–111 invalid.
- `target_sel` in 4: telemetry target index.
- `x_coord`, `y_coord`, `z_coord`, `t_coord` in 8 each: target position and time.
- `fire_valid` out 1: one-cycle fire strobe to the datapath.
- `fire_func` out 3: latched function.
- `fire_target` out 4: latched target.
- `fire_coord` out 32: latched {t,z,y,x}.
- `resp_valid` out 1: one-cycle completion strobe.
- `resp_code` out 2: 00 ok, 01 invalid function, 10 insufficient energy, 11 no tracer.
- `tracer_count` out 6: tracers held.
- `energy_level` out 8: energy remaining.
- `energy_empty` out 1: `energy_level == 0`.
- `reload_req` in 1: present only with `WEB_RELOAD_EN`.

## Operation
- FSM states: IDLE, CHECK, FIRE, RESP, COOLDOWN.
- IDLE: `req_ready`=1. When `req_valid` is high, latch all request fields and go to CHECK.
- CHECK: look up cost. Line=1 energy, ball=2, tracer=1 energy + 1 tracer, taser=4, NOP=0.
- Rejection priority is invalid > energy > tracer.
- Reject or NOP: go to RESP.
- Otherwise go to FIRE.
- FIRE: assert `fire_valid` and `resp_valid` with code 00. Subtract costs at the exit edge. Go to COOLDOWN, counter loaded with `COOLDOWN_CYCLES`.
- RESP: assert `resp_valid` with the computed code (00 for NOP). No fire. Counters unchanged. Go to IDLE.
- COOLDOWN: decrement the counter. Leave for IDLE on the edge where the counter reaches 0.
- Counters never underflow; the CHECK state guarantees this. An exact-cost shot (energy 2, ball) is legal and leaves 0.
- `energy_empty` is derived combinationally from the registered level.
- `fire_*` outputs hold their latched values between fires. They are valid only while `fire_valid`=1.
- `req_ready` is 0 in every state except IDLE. A request held across a busy period is accepted on the first IDLE cycle.

## Timing
- Reset: state IDLE, `req_ready`=1, `fire_valid`=0, `resp_valid`=0, `resp_code`=00, `fire_func`/`fire_target`/`fire_coord`=0, `tracer_count`=`TRACER_INIT`, `energy_level`=`ENERGY_MAX`, `energy_empty`=0.
- Let the accept edge be N.
  - CHECK occupies cycle N+1.
  - `fire_valid` or reject/NOP `resp_valid` is high in cycle N+2.
  - Updated counters are visible from N+3.
  - Next accept is possible at edge N+3+`COOLDOWN_CYCLES` after a fire, or N+3 after a reject or NOP.
- Reset asserted mid-operation aborts immediately: no fire strobe, counters return to reset values.

## Configuration
- `WEB_RELOAD_EN` defined:
  - Adds the `reload_req` port.
  - In IDLE with `req_valid`=0 and `reload_req`=1, the next edge sets `tracer_count`=63 and `energy_level`=`ENERGY_MAX`.
  - If `req_valid` and `reload_req` are both high, the request wins and the reload is ignored.
  - `reload_req` in any state other than IDLE is ignored.
- Undefined: no `reload_req` port; reserves only decrease until reset.

## Structure
- `web_pkg` holds:
  - function codes
  - response codes
  - FSM state enum
  - cost constants
  - tracer maximum 63
- Sub-module `web_cost_lut`: combinational decode of `func_sel` into {energy cost, tracer cost, invalid}. It is used by CHECK.

## Test plan
- Reset, then ball (010) at x=0x55, y=0xF0, z=0xAA, t=0xCC, target 1011 -> `fire_valid` in cycle N+2 with `fire_coord`=0xCCAAF055, `resp_code` 00, energy 253, `req_ready` low for 4 cooldown cycles.
- Tracer (011) repeated 32 times -> `tracer_count` 0. 33rd request -> `resp_code` 11, no fire, energy unchanged.
- Taser (100) with energy forced to 3 via repeated shots -> `resp_code` 10. A line shot then still succeeds; draining energy to 0 raises `energy_empty`.
- `func_sel`=110 -> `resp_code` 01 in cycle N+2, no cooldown, accepted again at N+3. NOP -> code 00 with no fire.
- `rst_n` pulled low during FIRE -> `fire_valid` drops at once, counters back to 255/32.
- With `WEB_RELOAD_EN`: drain tracers to 5, pulse `reload_req` in IDLE -> 63 tracers, energy 255. Reload together with `req_valid` -> request serviced, no reload.
